// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage core: load-use stalls, taken-branch
// flushes, the mult/div occupancy FSM and saturating perf counters.
module hazard_stall_controller #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_write_reg_addr,
    input  logic [4:0]       if_id_instr_rs,
    input  logic [4:0]       if_id_instr_rt,
    input  logic             if_id_uses_rt,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LATENCY - 3);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        LAST
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          mdu_stall;
    logic          br_flush;
    logic          last_cyc;
    logic          load_use;

    assign load_use = id_ex_mem_read
                   && (id_ex_write_reg_addr != 5'd0)
                   && ((id_ex_write_reg_addr == if_id_instr_rs)
                    || (if_id_uses_rt
                     && id_ex_write_reg_addr == if_id_instr_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A branch can only be resolved in EX while no MDU op occupies it
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mdu_stall  = 1'b0;
        br_flush   = 1'b0;
        last_cyc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (branch_taken) begin
                    br_flush = 1'b1;
                end else if (mdu_start) begin
                    mdu_stall  = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mdu_stall = 1'b1;
                if (cnt == '0) begin
                    state_next = LAST;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            LAST: begin
                last_cyc   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_done      = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else begin
            mdu_done = last_cyc;
            if (br_flush) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (mdu_stall) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (br_flush && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomised bench for hazard_stall_controller against a cycle-occupancy
// model of the pipeline hazard rules.
module tb_hazard_stall_controller;

    localparam int L = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_ex_mem_read;
    logic [4:0]   id_ex_write_reg_addr;
    logic [4:0]   if_id_instr_rs;
    logic [4:0]   if_id_instr_rt;
    logic         if_id_uses_rt;
    logic         branch_taken;
    logic         mdu_start;
    logic         perf_clr;
    logic         pc_write;
    logic         if_id_write;
    logic         id_ex_write;
    logic         if_id_flush;
    logic         id_ex_bubble;
    logic         ex_mem_bubble;
    logic         mdu_done;
    logic [W-1:0] stall_cycles;
    logic [W-1:0] flush_count;

    hazard_stall_controller #(
        .MDU_LATENCY(L),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_write_reg_addr(id_ex_write_reg_addr),
        .if_id_instr_rs(if_id_instr_rs),
        .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rt(if_id_uses_rt),
        .branch_taken(branch_taken),
        .mdu_start(mdu_start),
        .perf_clr(perf_clr),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_ex_write(id_ex_write),
        .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble),
        .mdu_done(mdu_done),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    // model: which EX-occupancy cycle (1..L) the MDU op is in, 0 = none
    int ex_cycle = 0;
    int m_stall = 0;
    int m_flush = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic mr,
                        input logic [4:0] wa, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt,
                        input logic br, input logic ms, input logic clr);
        logic [6:0] e;
        int occ;
        bit lu, beff, stl;
        int mx = (1 << W) - 1;
        @(negedge clk);
        reset = rst;
        id_ex_mem_read = mr;
        id_ex_write_reg_addr = wa;
        if_id_instr_rs = rs;
        if_id_instr_rt = rt;
        if_id_uses_rt = urt;
        branch_taken = br;
        mdu_start = ms;
        perf_clr = clr;
        #1;
        lu = mr && wa != 0 && (wa == rs || (urt && wa == rt));
        beff = br && ex_cycle == 0;
        occ = ex_cycle;
        if (ex_cycle == 0 && ms && !br) occ = 1;
        stl = occ >= 1 && occ < L;
        // {pc, if_id_w, id_ex_w, flush, id_ex_bub, ex_mem_bub, done}
        if (rst) begin
            e = 7'b0001110;
            ex_cycle = 0;
            occ = 0;
            beff = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (beff) e = 7'b1111100;
        else if (stl) e = 7'b0000010;
        else if (lu) e = 7'b0010100;
        else e = 7'b1110000;
        if (!rst && occ == L) e[0] = 1'b1;
        check("ctl", 32'({pc_write, if_id_write, id_ex_write, if_id_flush,
                          id_ex_bubble, ex_mem_bubble, mdu_done}), 32'(e));
        check("stall_cnt", 32'(stall_cycles), 32'(m_stall));
        check("flush_cnt", 32'(flush_count), 32'(m_flush));
        if (mdu_done) done_seen++;
        @(posedge clk);
        if (!rst) begin
            if (clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (!e[6] && m_stall < mx) m_stall++;
                if (beff && m_flush < mx) m_flush++;
            end
            ex_cycle = (occ == 0 || occ == L) ? 0 : occ + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        id_ex_mem_read = 0;
        id_ex_write_reg_addr = 0;
        if_id_instr_rs = 0;
        if_id_instr_rt = 0;
        if_id_uses_rt = 0;
        branch_taken = 0;
        mdu_start = 0;
        perf_clr = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        step(0, 1, 5, 5, 0, 0, 0, 0, 0);
        check("lu_once", 32'(stall_cycles), 32'd1);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 7, 1, 7, 0, 0, 0, 0);
        step(0, 1, 7, 1, 7, 1, 0, 0, 0);
        check("lu_rt", 32'(stall_cycles), 32'd2);

        clear();
        done_seen = 0;
        for (int i = 0; i < L; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        check("mdu_stall", 32'(stall_cycles), 32'(L - 1));
        check("mdu_done", 32'(done_seen), 32'd1);

        clear();
        done_seen = 0;
        for (int i = 0; i < 2 * L; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        check("b2b_stall", 32'(stall_cycles), 32'(2 * (L - 1)));
        check("b2b_done", 32'(done_seen), 32'd2);

        clear();
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("br_flush", 32'(flush_count), 32'd1);
        step(0, 1, 5, 5, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);
        check("br_nostall", 32'(stall_cycles), 32'd0);

        done_seen = 0;
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(L + 1);
        check("abort_done", 32'(done_seen), 32'd0);

        clear();
        for (int i = 0; i < 20; i++) step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        check("sat", 32'(stall_cycles), 32'd15);
        step(0, 1, 3, 3, 0, 0, 0, 0, 1);
        check("clr", 32'(stall_cycles), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic rst_r, br_r, ms_r;
            rst_r = ($urandom_range(0, 60) == 0);
            br_r = (ex_cycle == 0) && ($urandom_range(0, 5) == 0);
            if (ex_cycle != 0 && ex_cycle != L) ms_r = 1'b1;
            else ms_r = ($urandom_range(0, 5) == 0);
            step(rst_r, 1'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), br_r, ms_r,
                 ($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
